// File: rtl/frame_ram_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : frame_ram_scheduler_if                                         |
// | Bundles the VGA fetch, collision probe, rectangle fill and frame RAM       |
// | port signals owned by frame_ram_scheduler.                                 |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface frame_ram_scheduler_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  // VGA pixel fetch
  logic              vga_req;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  // Collision probe
  logic              probe_req;
  logic [9:0]        probe_x;
  logic [9:0]        probe_y;
  logic              probe_ack;
  logic [DATA_W-1:0] probe_data;
  // Rectangle fill
  logic              fill_start;
  logic [9:0]        fill_x0;
  logic [9:0]        fill_y0;
  logic [9:0]        fill_x1;
  logic [9:0]        fill_y1;
  logic [DATA_W-1:0] fill_color;
  logic              vblank;
  logic              fill_busy;
  logic              fill_done;
  // Frame RAM ports
  logic              ram_we;
  logic [ADDR_W-1:0] ram_write_address;
  logic [4:0]        ram_data_in;
  logic [ADDR_W-1:0] ram_read_address;
  logic [4:0]        ram_data_out;

  // Scheduler side
  modport slave (
    input  vga_req, DrawX, DrawY, probe_req, probe_x, probe_y,
           fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
           vblank, ram_data_out,
    output vga_data, vga_valid, probe_ack, probe_data, fill_busy, fill_done,
           ram_we, ram_write_address, ram_data_in, ram_read_address
  );

  // Environment side (VGA controller, game FSM, frame RAM)
  modport master (
    output vga_req, DrawX, DrawY, probe_req, probe_x, probe_y,
           fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
           vblank, ram_data_out,
    input  vga_data, vga_valid, probe_ack, probe_data, fill_busy, fill_done,
           ram_we, ram_write_address, ram_data_in, ram_read_address
  );
endinterface
`default_nettype wire

// File: rtl/frame_ram_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_ram_scheduler                                             |
// | Sole owner of the background frame RAM. Read port: VGA fetch has priority  |
// | over collision probes, 2-cycle fixed return latency. Write port: rectangle |
// | fill engine, one pixel per cycle in raster order.                          |
// | Option   : FRAME_RAM_VBLANK_FILL_EN - fill writes only while vblank=1.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module frame_ram_scheduler #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
) (
  input  wire logic            Clk,
  input  wire logic            Reset_n,
  frame_ram_scheduler_if.slave bus
);

  localparam logic [9:0]        c_X_MAX    = 10'(H_RES - 1);
  localparam logic [9:0]        c_Y_MAX    = 10'(V_RES - 1);
  localparam logic [ADDR_W-1:0] c_ROW_STEP = ADDR_W'(H_RES);

  // Linear address y*H_RES + x; a constant multiply reduces to shift-adds.
  function automatic logic [ADDR_W-1:0] f_lin_addr(input logic [9:0] x, input logic [9:0] y);
    return (ADDR_W'(y) * c_ROW_STEP) + ADDR_W'(x);
  endfunction

  // --------------------------------------------------------------------------
  // Read arbiter
  // --------------------------------------------------------------------------
  // Owner of the read slot; OWN_OOR is an out-of-range probe that never touches
  // the RAM but still returns on the same 2-cycle schedule with zero data.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_PRB  = 2'd2,
    OWN_OOR  = 2'd3
  } owner_t;

  owner_t            r_own_s0;
  owner_t            r_own_s1;
  logic              r_prb_busy;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_vga_data;
  logic [DATA_W-1:0] r_prb_data;
  logic              r_vga_valid;
  logic              r_prb_ack;

  logic w_prb_in_range;
  logic w_prb_take;
  logic w_prb_ret;

  assign w_prb_in_range = (bus.probe_x <= c_X_MAX) && (bus.probe_y <= c_Y_MAX);
  // A probe is taken once; busy blocks re-issue while the held request is in flight.
  assign w_prb_take     = bus.probe_req && !r_prb_busy && !bus.vga_req;
  assign w_prb_ret      = (r_own_s1 == OWN_PRB) || (r_own_s1 == OWN_OOR);

  // Issue one read per cycle and route returning data to the tagged owner.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_own_s0    <= OWN_NONE;
      r_own_s1    <= OWN_NONE;
      r_prb_busy  <= 1'b0;
      r_rd_addr   <= '0;
      r_vga_data  <= '0;
      r_prb_data  <= '0;
      r_vga_valid <= 1'b0;
      r_prb_ack   <= 1'b0;
    end else begin
      r_own_s1 <= r_own_s0;

      if (bus.vga_req) begin
        r_rd_addr <= f_lin_addr(bus.DrawX, bus.DrawY);
        r_own_s0  <= OWN_VGA;
      end else if (w_prb_take) begin
        if (w_prb_in_range) begin
          r_rd_addr <= f_lin_addr(bus.probe_x, bus.probe_y);
          r_own_s0  <= OWN_PRB;
        end else begin
          r_own_s0  <= OWN_OOR;
        end
      end else begin
        r_own_s0 <= OWN_NONE;
      end

      if (w_prb_ret) begin
        r_prb_busy <= 1'b0;
      end else if (w_prb_take) begin
        r_prb_busy <= 1'b1;
      end

      r_vga_valid <= (r_own_s1 == OWN_VGA);
      if (r_own_s1 == OWN_VGA) begin
        r_vga_data <= bus.ram_data_out[DATA_W-1:0];
      end

      r_prb_ack <= w_prb_ret;
      if (r_own_s1 == OWN_PRB) begin
        r_prb_data <= bus.ram_data_out[DATA_W-1:0];
      end else if (r_own_s1 == OWN_OOR) begin
        r_prb_data <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Rectangle fill engine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_SETUP = 2'd1,
    F_WRITE = 2'd2,
    F_DONE  = 2'd3
  } fill_state_t;

  fill_state_t       r_fstate;
  logic [9:0]        r_fx0;
  logic [9:0]        r_fy0;
  logic [9:0]        r_fx1;
  logic [9:0]        r_fy1;
  logic [DATA_W-1:0] r_color;
  logic [9:0]        r_xmin;
  logic [9:0]        r_xmax;
  logic [9:0]        r_ymax;
  logic [9:0]        r_cx;
  logic [9:0]        r_cy;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_row;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;

  logic [9:0] w_xlo;
  logic [9:0] w_xhi;
  logic [9:0] w_ylo;
  logic [9:0] w_yhi;
  logic [9:0] w_xhi_c;
  logic [9:0] w_yhi_c;
  logic       w_off;
  logic       w_adv;
  logic       w_unused;

  assign w_xlo   = (r_fx0 < r_fx1) ? r_fx0 : r_fx1;
  assign w_xhi   = (r_fx0 < r_fx1) ? r_fx1 : r_fx0;
  assign w_ylo   = (r_fy0 < r_fy1) ? r_fy0 : r_fy1;
  assign w_yhi   = (r_fy0 < r_fy1) ? r_fy1 : r_fy0;
  assign w_xhi_c = (w_xhi > c_X_MAX) ? c_X_MAX : w_xhi;
  assign w_yhi_c = (w_yhi > c_Y_MAX) ? c_Y_MAX : w_yhi;
  // Nothing to draw when the top-left corner already lies past the screen.
  assign w_off   = (w_xlo > c_X_MAX) || (w_ylo > c_Y_MAX);

`ifdef FRAME_RAM_VBLANK_FILL_EN
  assign w_adv    = bus.vblank;
  assign w_unused = ^bus.ram_data_out[4:DATA_W];
`else
  assign w_adv    = 1'b1;
  assign w_unused = ^{bus.ram_data_out[4:DATA_W], bus.vblank};
`endif

  // Fill FSM: latch request, sort/clip corners, stream pixels, pulse done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fstate <= F_IDLE;
      r_fx0    <= '0;
      r_fy0    <= '0;
      r_fx1    <= '0;
      r_fy1    <= '0;
      r_color  <= '0;
      r_xmin   <= '0;
      r_xmax   <= '0;
      r_ymax   <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_addr   <= '0;
      r_row    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_fstate)
        F_IDLE: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
          if (bus.fill_start) begin
            r_fx0    <= bus.fill_x0;
            r_fy0    <= bus.fill_y0;
            r_fx1    <= bus.fill_x1;
            r_fy1    <= bus.fill_y1;
            r_color  <= bus.fill_color;
            r_busy   <= 1'b1;
            r_fstate <= F_SETUP;
          end
        end
        F_SETUP: begin
          if (w_off) begin
            r_done   <= 1'b1;
            r_fstate <= F_DONE;
          end else begin
            r_xmin   <= w_xlo;
            r_xmax   <= w_xhi_c;
            r_ymax   <= w_yhi_c;
            r_cx     <= w_xlo;
            r_cy     <= w_ylo;
            r_addr   <= f_lin_addr(w_xlo, w_ylo);
            r_row    <= f_lin_addr(w_xlo, w_ylo);
            r_fstate <= F_WRITE;
          end
        end
        F_WRITE: begin
          r_we <= w_adv;
          if (w_adv) begin
            r_waddr <= r_addr;
            r_wdata <= r_color;
            if (r_cx == r_xmax) begin
              if (r_cy == r_ymax) begin
                r_done   <= 1'b1;
                r_fstate <= F_DONE;
              end else begin
                r_cx   <= r_xmin;
                r_cy   <= r_cy + 10'd1;
                r_row  <= r_row + c_ROW_STEP;
                r_addr <= r_row + c_ROW_STEP;
              end
            end else begin
              r_cx   <= r_cx + 10'd1;
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
          r_we     <= 1'b0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_fstate <= F_IDLE;
        end
      endcase
    end
  end

  assign bus.vga_data          = r_vga_data;
  assign bus.vga_valid         = r_vga_valid;
  assign bus.probe_ack         = r_prb_ack;
  assign bus.probe_data        = r_prb_data;
  assign bus.ram_read_address  = r_rd_addr;
  assign bus.fill_busy         = r_busy;
  assign bus.fill_done         = r_done;
  assign bus.ram_we            = r_we;
  assign bus.ram_write_address = r_waddr;
  assign bus.ram_data_in       = {{(5-DATA_W){1'b0}}, r_wdata};

endmodule
`default_nettype wire
